parking_gate_controller: RTL and testbench

Entry/exit gate front end for the parking occupancy tracker: debounces the raw vehicle-loop sensors at both gates and samples the university badge reader. Entry is decided against the tracker's vacancy flags, and the controller drives both barriers. It generates the active-low, one-cycle `car_entered` / `car_exited` strobes and the `is_uni_*` qualifiers that the tracker consumes. It sits between the gate hardware and the tracker, on the tracker's clock.

---
 rtl/parking_gate_controller_if.sv | 27 ++
 rtl/parking_gate_controller.sv | 217 +++++++++++++++++++++
 tb/tb_parking_gate_controller.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/parking_gate_controller_if.sv
// rtl/parking_gate_controller_if.sv - tracker-side strobe and vacancy signals
interface parking_gate_controller_if;
    logic car_entered;
    logic is_uni_car_entered;
    logic car_exited;
    logic is_uni_car_exited;
    logic uni_is_vacated_space;
    logic is_vacated_space;

    modport master (
        output car_entered,
        output is_uni_car_entered,
        output car_exited,
        output is_uni_car_exited,
        input  uni_is_vacated_space,
        input  is_vacated_space
    );

    modport slave (
        input  car_entered,
        input  is_uni_car_entered,
        input  car_exited,
        input  is_uni_car_exited,
        output uni_is_vacated_space,
        output is_vacated_space
    );
endinterface

// File: rtl/parking_gate_controller.sv
// rtl/parking_gate_controller.sv - entry/exit gate debounce, barrier control and strobe arbiter
module parking_gate_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int OPEN_CYCLES     = 2000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic loop_in,
    input  logic uni_tag_in,
    input  logic loop_out,
    input  logic uni_tag_out,
    parking_gate_controller_if.master trk,
    output logic barrier_in_open,
    output logic barrier_out_open,
    output logic entry_denied,
    output logic gate_timeout
);
    typedef enum logic [2:0] {
        S_IDLE, S_ARRIVE, S_OPEN, S_LEAVE, S_DENY, S_CLEAR
    } gate_state_t;

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int OW = $clog2(OPEN_CYCLES + 1);
    localparam logic [DW-1:0] DEB_ONE   = DW'(1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [OW-1:0] OPEN_ONE  = OW'(1);
    localparam logic [OW-1:0] OPEN_LAST = OW'(OPEN_CYCLES - 1);

    gate_state_t    in_state, out_state;
    logic [DW-1:0]  in_deb, out_deb;
    logic [OW-1:0]  in_open_cnt, out_open_cnt;
    logic           in_uni, out_uni;
    logic           pend, pend_uni;

    logic in_vacant, in_strobe, out_strobe, in_timeout, out_timeout;
    logic ent_req, ent_uni;

    // The class register is sampled at the decision edge, so the vacancy choice uses the live tag.
    assign in_vacant   = uni_tag_in ? trk.uni_is_vacated_space : trk.is_vacated_space;
    assign in_strobe   = (in_state == S_LEAVE) && !loop_in && (in_deb == DEB_LAST);
    assign out_strobe  = (out_state == S_LEAVE) && !loop_out && (out_deb == DEB_LAST);
    assign in_timeout  = (in_state == S_OPEN) && loop_in && (in_open_cnt == OPEN_LAST);
    assign out_timeout = (out_state == S_OPEN) && loop_out && (out_open_cnt == OPEN_LAST);
    assign ent_req     = in_strobe | pend;
    assign ent_uni     = pend ? pend_uni : in_uni;

    // Entry gate: debounce, vacancy decision, barrier and deny flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_state        <= S_IDLE;
            in_deb          <= '0;
            in_open_cnt     <= '0;
            in_uni          <= 1'b0;
            barrier_in_open <= 1'b0;
            entry_denied    <= 1'b0;
        end else begin
            case (in_state)
                S_IDLE: begin
                    in_deb <= loop_in ? DEB_ONE : '0;
                    if (loop_in) in_state <= S_ARRIVE;
                end
                S_ARRIVE: begin
                    if (!loop_in) begin
                        in_state <= S_IDLE;
                        in_deb   <= '0;
                    end else if (in_deb == DEB_LAST) begin
                        in_uni      <= uni_tag_in;
                        in_deb      <= '0;
                        in_open_cnt <= '0;
                        if (in_vacant) begin
                            in_state        <= S_OPEN;
                            barrier_in_open <= 1'b1;
                        end else begin
                            in_state     <= S_DENY;
                            entry_denied <= 1'b1;
                        end
                    end else begin
                        in_deb <= in_deb + DEB_ONE;
                    end
                end
                S_OPEN: begin
                    if (!loop_in) begin
                        in_state <= S_LEAVE;
                        in_deb   <= DEB_ONE;
                    end else if (in_timeout) begin
                        in_state        <= S_CLEAR;
                        barrier_in_open <= 1'b0;
                        in_deb          <= '0;
                    end else begin
                        in_open_cnt <= in_open_cnt + OPEN_ONE;
                    end
                end
                S_LEAVE: begin
                    if (loop_in) begin
                        in_state <= S_OPEN;
                        in_deb   <= '0;
                    end else if (in_deb == DEB_LAST) begin
                        in_state        <= S_IDLE;
                        in_deb          <= '0;
                        barrier_in_open <= 1'b0;
                    end else begin
                        in_deb <= in_deb + DEB_ONE;
                    end
                end
                S_DENY, S_CLEAR: begin
                    if (loop_in) begin
                        in_deb <= '0;
                    end else if (in_deb == DEB_LAST) begin
                        in_state     <= S_IDLE;
                        in_deb       <= '0;
                        entry_denied <= 1'b0;
                    end else begin
                        in_deb <= in_deb + DEB_ONE;
                    end
                end
                default: in_state <= S_IDLE;
            endcase
        end
    end

    // Exit gate: same debounce and timeout rules, always opens.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_state        <= S_IDLE;
            out_deb          <= '0;
            out_open_cnt     <= '0;
            out_uni          <= 1'b0;
            barrier_out_open <= 1'b0;
        end else begin
            case (out_state)
                S_IDLE: begin
                    out_deb <= loop_out ? DEB_ONE : '0;
                    if (loop_out) out_state <= S_ARRIVE;
                end
                S_ARRIVE: begin
                    if (!loop_out) begin
                        out_state <= S_IDLE;
                        out_deb   <= '0;
                    end else if (out_deb == DEB_LAST) begin
                        out_uni          <= uni_tag_out;
                        out_deb          <= '0;
                        out_open_cnt     <= '0;
                        out_state        <= S_OPEN;
                        barrier_out_open <= 1'b1;
                    end else begin
                        out_deb <= out_deb + DEB_ONE;
                    end
                end
                S_OPEN: begin
                    if (!loop_out) begin
                        out_state <= S_LEAVE;
                        out_deb   <= DEB_ONE;
                    end else if (out_timeout) begin
                        out_state        <= S_CLEAR;
                        barrier_out_open <= 1'b0;
                        out_deb          <= '0;
                    end else begin
                        out_open_cnt <= out_open_cnt + OPEN_ONE;
                    end
                end
                S_LEAVE: begin
                    if (loop_out) begin
                        out_state <= S_OPEN;
                        out_deb   <= '0;
                    end else if (out_deb == DEB_LAST) begin
                        out_state        <= S_IDLE;
                        out_deb          <= '0;
                        barrier_out_open <= 1'b0;
                    end else begin
                        out_deb <= out_deb + DEB_ONE;
                    end
                end
                S_CLEAR: begin
                    if (loop_out) begin
                        out_deb <= '0;
                    end else if (out_deb == DEB_LAST) begin
                        out_state <= S_IDLE;
                        out_deb   <= '0;
                    end else begin
                        out_deb <= out_deb + DEB_ONE;
                    end
                end
                default: out_state <= S_IDLE;
            endcase
        end
    end

    // Strobe arbiter: exit wins a collision, the entry strobe waits one cycle in pend.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trk.car_entered        <= 1'b1;
            trk.is_uni_car_entered <= 1'b0;
            trk.car_exited         <= 1'b1;
            trk.is_uni_car_exited  <= 1'b0;
            pend                   <= 1'b0;
            pend_uni               <= 1'b0;
            gate_timeout           <= 1'b0;
        end else begin
            gate_timeout <= in_timeout | out_timeout;
            if (out_strobe) begin
                trk.car_exited         <= 1'b0;
                trk.is_uni_car_exited  <= out_uni;
                trk.car_entered        <= 1'b1;
                trk.is_uni_car_entered <= 1'b0;
                pend                   <= ent_req;
                pend_uni               <= ent_uni;
            end else begin
                trk.car_exited         <= 1'b1;
                trk.is_uni_car_exited  <= 1'b0;
                trk.car_entered        <= !ent_req;
                trk.is_uni_car_entered <= ent_req & ent_uni;
                pend                   <= 1'b0;
                pend_uni               <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_parking_gate_controller.sv
// tb/tb_parking_gate_controller.sv - scoreboard bench with behavioural gate model
module tb_parking_gate_controller;
    localparam int D  = 4;
    localparam int OC = 20;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic loop_in = 1'b0, uni_tag_in = 1'b0, loop_out = 1'b0, uni_tag_out = 1'b0;
    logic barrier_in_open, barrier_out_open, entry_denied, gate_timeout;

    parking_gate_controller_if trk();

    parking_gate_controller #(.DEBOUNCE_CYCLES(D), .OPEN_CYCLES(OC)) dut (
        .clk(clk), .reset_n(reset_n),
        .loop_in(loop_in), .uni_tag_in(uni_tag_in),
        .loop_out(loop_out), .uni_tag_out(uni_tag_out),
        .trk(trk),
        .barrier_in_open(barrier_in_open), .barrier_out_open(barrier_out_open),
        .entry_denied(entry_denied), .gate_timeout(gate_timeout)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; bit is_exit; bit uni; } strobe_t;
    strobe_t exp_q[$];

    // Behavioural model: per gate, the length of the current loop run decides everything.
    bit lvl[2];
    int run[2];
    bit busy[2];
    int mode[2];   // 0 car passing, 1 refused, 2 timed out
    int otime[2];
    bit cls[2];
    bit exp_bar[2];
    bit exp_den, exp_tmo;
    bit entq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < 2; g++) begin
            lvl[g] = 0; run[g] = 0; busy[g] = 0; mode[g] = 0;
            otime[g] = 0; cls[g] = 0; exp_bar[g] = 0;
        end
        exp_den = 0;
        exp_tmo = 0;
        entq.delete();
    endtask

    task automatic gate_step(input int g, input bit l, input bit tag, input bit vacok,
                             output bit strobe, output bit s_uni, output bit tmo);
        strobe = 0;
        tmo = 0;
        if (l == lvl[g]) run[g] = run[g] + 1;
        else begin lvl[g] = l; run[g] = 1; end
        if (!busy[g]) begin
            if (l && run[g] == D) begin
                busy[g] = 1; cls[g] = tag; otime[g] = 0;
                if (vacok) begin mode[g] = 0; exp_bar[g] = 1; end
                else begin mode[g] = 1; exp_den = 1; end
            end
        end else if (mode[g] == 0) begin
            if (l && run[g] > 1) begin
                otime[g] = otime[g] + 1;
                if (otime[g] == OC) begin mode[g] = 2; exp_bar[g] = 0; tmo = 1; end
            end else if (!l && run[g] == D) begin
                busy[g] = 0; exp_bar[g] = 0; strobe = 1;
            end
        end else if (!l && run[g] == D) begin
            busy[g] = 0;
            if (mode[g] == 1) exp_den = 0;
        end
        s_uni = cls[g];
    endtask

    task automatic model_step(input bit li, ti, lo, to, uv, v);
        bit se, ue, t0, sx, ux, t1;
        strobe_t s;
        gate_step(0, li, ti, ti ? uv : v, se, ue, t0);
        gate_step(1, lo, to, 1'b1, sx, ux, t1);
        exp_tmo = t0 | t1;
        if (se) entq.push_back(ue);
        s.cyc = cyc + 1;
        if (sx) begin
            s.is_exit = 1; s.uni = ux; exp_q.push_back(s);
        end else if (entq.size() > 0) begin
            s.is_exit = 0; s.uni = entq.pop_front(); exp_q.push_back(s);
        end
    endtask

    // One stimulus cycle: check last edge's outputs, apply inputs, advance the model.
    task automatic cycle(input bit li, ti, lo, to, uv, v, rn);
        @(negedge clk);
        chk("barrier_in_open", barrier_in_open, exp_bar[0]);
        chk("barrier_out_open", barrier_out_open, exp_bar[1]);
        chk("entry_denied", entry_denied, exp_den);
        chk("gate_timeout", gate_timeout, exp_tmo);
        loop_in = li; uni_tag_in = ti; loop_out = lo; uni_tag_out = to;
        trk.uni_is_vacated_space = uv;
        trk.is_vacated_space = v;
        if (!rn) begin
            if (reset_n) begin
                reset_n = 0;
                #1;
                chk("async_rst_barrier_in", barrier_in_open, 0);
                chk("async_rst_barrier_out", barrier_out_open, 0);
                chk("async_rst_car_entered", trk.car_entered, 1);
                chk("async_rst_car_exited", trk.car_exited, 1);
            end
            model_reset();
        end else begin
            reset_n = 1;
            model_step(li, ti, lo, to, uv, v);
        end
    endtask

    task automatic run_n(input int n, input bit li, ti, lo, to, uv, v);
        for (int i = 0; i < n; i++) cycle(li, ti, lo, to, uv, v, 1'b1);
    endtask

    // Monitor: compares strobe outputs against the scoreboard every cycle.
    initial begin
        strobe_t e;
        bit has_exp;
        forever begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                chk("strobe_missing", 0, 1);
            end
            has_exp = (exp_q.size() > 0 && exp_q[0].cyc == cyc);
            if (has_exp) e = exp_q.pop_front();
            else begin e.cyc = cyc; e.is_exit = 0; e.uni = 0; end
            chk("strobe_exclusive", (trk.car_entered === 1'b0) && (trk.car_exited === 1'b0), 0);
            chk("car_entered", trk.car_entered, (has_exp && !e.is_exit) ? 0 : 1);
            chk("car_exited", trk.car_exited, (has_exp && e.is_exit) ? 0 : 1);
            chk("is_uni_car_entered", trk.is_uni_car_entered, (has_exp && !e.is_exit) ? e.uni : 0);
            chk("is_uni_car_exited", trk.is_uni_car_exited, (has_exp && e.is_exit) ? e.uni : 0);
        end
    end

    initial begin
        int seg[2];
        bit lv[2];
        bit tg[2];
        model_reset();
        trk.uni_is_vacated_space = 0;
        trk.is_vacated_space = 0;
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 1'b0);
        run_n(3, 0, 0, 0, 0, 0, 0);
        // uni entry with space
        run_n(8, 1, 1, 0, 0, 1, 0);
        run_n(6, 0, 0, 0, 0, 0, 0);
        // bounce rejection
        run_n(2, 1, 1, 0, 0, 1, 1);
        run_n(1, 0, 0, 0, 0, 1, 1);
        run_n(2, 1, 1, 0, 0, 1, 1);
        run_n(5, 0, 0, 0, 0, 1, 1);
        // full lot for visitors
        run_n(7, 1, 0, 0, 0, 1, 0);
        run_n(6, 0, 0, 0, 0, 1, 0);
        // exit timeout
        run_n(30, 0, 0, 1, 1, 1, 1);
        run_n(6, 0, 0, 0, 0, 1, 1);
        // simultaneous strobes
        run_n(6, 1, 0, 1, 1, 1, 1);
        run_n(8, 0, 0, 0, 0, 1, 1);
        // collision then reset while the entry strobe is pending
        run_n(6, 1, 1, 1, 0, 1, 1);
        run_n(D, 0, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 1, 1, 1'b0);
        cycle(0, 0, 0, 0, 1, 1, 1'b0);
        run_n(6, 0, 0, 0, 0, 1, 1);
        // car present across reset is a new arrival
        run_n(8, 1, 1, 0, 0, 1, 1);
        cycle(1, 1, 0, 0, 1, 1, 1'b0);
        run_n(8, 1, 1, 0, 0, 1, 1);
        run_n(6, 0, 0, 0, 0, 1, 1);
        // randomized traffic
        seg[0] = 0; seg[1] = 0; lv[0] = 0; lv[1] = 0; tg[0] = 0; tg[1] = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int g = 0; g < 2; g++) begin
                if (seg[g] == 0) begin
                    lv[g] = ~lv[g];
                    seg[g] = ($urandom_range(0, 9) == 0) ? $urandom_range(OC + 2, OC + 10)
                                                         : $urandom_range(1, 9);
                    tg[g] = 1'($urandom_range(0, 1));
                end
                seg[g]--;
            end
            if ($urandom_range(0, 599) == 0) begin
                cycle(lv[0], tg[0], lv[1], tg[1], 1, 1, 1'b0);
                cycle(lv[0], tg[0], lv[1], tg[1], 1, 1, 1'b0);
            end else begin
                cycle(lv[0], tg[0], lv[1], tg[1],
                      $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'b1);
            end
        end
        run_n(40, 0, 0, 0, 0, 1, 1);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
